// File: rtl/fd_queue.sv
// Fetch-to-decode instruction queue: DEPTH-entry FIFO carrying
// {instr, PC, PC+4, ISA tag} from fetch to decode, with StallD/FlushD
// semantics of the old pipeline register plus valid/ready flow control.
module fd_queue #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNTW  = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ValidF,
  output logic            ReadyF,
  input  logic [XLEN-1:0] InstrF,
  input  logic [XLEN-1:0] PCF,
  input  logic [XLEN-1:0] PCPlus4F,
  input  logic            armF,
  output logic            ValidD,
  output logic [XLEN-1:0] InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            armD,
  input  logic            StallD,
  input  logic            FlushD,
  output logic [CNTW-1:0] Count
);

  localparam int unsigned PW = $clog2(DEPTH);

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic            arm;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0] count_q,  count_d;
  logic            push, pop;
  entry_t          entry_in, head;

  // Flow-control status comes straight from the registered occupancy
  assign ReadyF = (count_q < CNTW'(DEPTH));
  assign ValidD = (count_q != '0);
  assign Count  = count_q;

  // Handshakes; flush overrides both
  assign push = ValidF & ReadyF & ~FlushD;
  assign pop  = ValidD & ~StallD & ~FlushD;

  assign entry_in = '{instr: InstrF, pc: PCF, pc_plus4: PCPlus4F, arm: armF};

  // Head is a combinational read, forced to a zero bubble when empty
  always_comb begin
    head     = mem_q[rd_ptr_q];
    InstrD   = '0;
    PCD      = '0;
    PCPlus4D = '0;
    armD     = 1'b0;
    if (ValidD) begin
      InstrD   = head.instr;
      PCD      = head.pc;
      PCPlus4D = head.pc_plus4;
      armD     = head.arm;
    end
  end

  // Next pointer/occupancy; flush clears everything and wins over push/pop
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (FlushD) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNTW'(1);
        2'b01:   count_d = count_q - CNTW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= entry_in;
  end

endmodule
